multicycle_controlunit: RTL and testbench
=========================================

# multicycle_controlunit

Sequenced control unit for the 8-bit accumulator computer. It replaces purely decode-driven control with a state machine that steps each instruction through fetch, decode, execute and memory phases over the single shared von Neumann memory port. It handshakes with memory through a req/ack pair with a bounded wait, issues single-cycle write enables, and enters a sticky fault state on illegal opcodes or memory timeouts. It sits between the instruction register / memory interface and the datapath (PC, RF, accumulator, ALU).

## Interface
- OPCODE_W, 3, opcode field width; must be ≥3; any opcode with a nonzero bit above bit 2 is illegal
- TIMEOUT, 15, max cycles mem_req may stay high without mem_ack; 0 disables the timeout
- CNT_W, 16, width of the retired-instruction counter
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; synchronous, active-high
- opcode  in  OPCODE_W  opcode field from instruction memory data; captured only in FETCH on mem_ack
- mem_ack  in  1  memory completion; may assert in the same cycle as mem_req; ignored when mem_req=0
- mem_req  out  1  memory access request
- memWE  out  1  DM write; only with mem_req in MEM for SW
- selMemIn  out  1  address source: 0=PC (fetch), 1=accumulator (LW/SW)
- irWE  out  1  instruction register load
- pcWE  out  1  PC update, asserted in the final cycle of every instruction
- brnch  out  1  PC selects the branch target when pcWE=1
- regWE, accWE, selAluIn, lw, selAccIn  out  1 each  datapath controls, same encodings as in the current control unit
- cntr_alu  out  2  00 add, 01 nand, 10 !=0, 11 less
- fault  out  1  sticky error flag
- retired  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W

## Operation
- States: FETCH, DECODE, EXEC, MEM, FAULT. Outputs are combinational in state, latched opcode and mem_ack. Every output not listed for a state is 0.
- FETCH: mem_req=1, selMemIn=0. On mem_ack: irWE=1, opcode latched, go to DECODE.
- DECODE: one cycle. An illegal opcode goes to FAULT; any other opcode goes to EXEC.
- EXEC by opcode. Each case below asserts pcWE and returns to FETCH unless stated otherwise:
  - 000 ACM: accWE=1, selAccIn=0.
  - 001 ACMI: accWE=1, selAccIn=1.
  - 010/011/101: regWE=1, selAluIn=1, lw=0, cntr_alu=00/01/11.
  - 100 BNZ: regWE=1, selAluIn=0, cntr_alu=10, brnch=1.
  - 110/111: no enables; go to MEM, with pcWE withheld.
- MEM: mem_req=1, selMemIn=1. For SW, memWE=1 is held with mem_req. On mem_ack: SW asserts pcWE; LW asserts regWE=1, lw=1, pcWE. Both return to FETCH.
- Timeout: wait counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 and mem_ack=0. When it reaches TIMEOUT, go to FAULT. If mem_ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins.
- FAULT: fault=1 and all enables 0, held until rst.
- retired increments in every cycle pcWE=1.

## Timing
- While rst=1: state ← FETCH, retired ← 0, fault ← 0, wait counter ← 0, and all outputs are forced to 0, including mem_req.
- First cycle with rst=0: mem_req=1 in FETCH.
- Zero-wait memory (ack in the same cycle as req): ALU, ACM and BNZ instructions take 3 cycles; LW and SW take 4. Each cycle of ack delay adds one cycle.
- rst asserted mid-instruction aborts it at the next edge. No pcWE and no write enable is issued in the rst cycle.
- mem_req, memWE and selMemIn stay stable from assertion until the ack cycle inclusive.

## Structure
- Shared package `ctrl_pkg` holds:
  - opcode constants (OP_ACM … OP_LW)
  - ALU op constants (ALU_ADD, ALU_NAND, ALU_NZ, ALU_LT)
  - state enum type
- Sub-module `mem_wait_timer`: parameter TIMEOUT; inputs clk, rst, clear, busy; output expired.

## Test plan
- rst held 3 cycles, then released with ack tied high → all outputs 0 during reset; mem_req=1 in the first free cycle.
- ACMI (001) with zero-wait ack → irWE at cycle 0, accWE=1 with selAccIn=1 and pcWE at cycle 2; retired 0→1.
- LW (111) with ack delayed 2 cycles in MEM → selMemIn=1 throughout MEM; regWE=1, lw=1, pcWE only in the ack cycle; 6 cycles total.
- SW (110) with ack never asserted, TIMEOUT=4 → FAULT after 4 waiting cycles with fault=1 and memWE=0. Re-run with ack arriving exactly in the 4th waiting cycle → completes normally, no fault.
- OPCODE_W=4, opcode 1010 → DECODE goes to FAULT; no enables issued; retired unchanged.
- rst pulsed during MEM of LW → no regWE or pcWE; restarts in FETCH with retired=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the multicycle control unit of the 8-bit
// accumulator computer: instruction opcodes (low three bits of the opcode
// field), ALU operation selects driven on cntr_alu, and the sequencer state
// type.
package ctrl_pkg;

  localparam logic [2:0] OP_ACM  = 3'b000;
  localparam logic [2:0] OP_ACMI = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_BNZ  = 3'b100;
  localparam logic [2:0] OP_LT   = 3'b101;
  localparam logic [2:0] OP_SW   = 3'b110;
  localparam logic [2:0] OP_LW   = 3'b111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_NAND = 2'b01;
  localparam logic [1:0] ALU_NZ   = 2'b10;
  localparam logic [1:0] ALU_LT   = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_FAULT
  } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
// Counts consecutive cycles in which a memory request is outstanding without
// an acknowledge and flags the cycle in which the count would reach TIMEOUT.
// TIMEOUT = 0 disables the timer entirely.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   clear   in  restart the count (no request waiting this cycle)
//   busy    in  request outstanding and not acknowledged this cycle
//   expired out this busy cycle is the TIMEOUT-th consecutive waiting cycle
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic busy,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Expiry is flagged combinationally in the waiting cycle that would make
  // the count reach TIMEOUT, so an ack in that same cycle (busy=0) wins.
  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      assign expired = busy && (count_q == CW'(TIMEOUT - 1));
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (busy && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_controlunit.sv
// multicycle_controlunit
// Sequences each instruction through FETCH, DECODE, EXEC and MEM over the
// single shared memory port, with a bounded req/ack wait and a sticky FAULT
// state for illegal opcodes and memory timeouts.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   opcode   [OPCODE_W]         opcode field, captured in FETCH on mem_ack
//   mem_ack                     memory completion
//   mem_req, memWE, selMemIn    memory request, data write, address select
//   irWE, pcWE, brnch           IR load, PC update, PC branch select
//   regWE, accWE, selAluIn,
//   lw, selAccIn, cntr_alu[2]   datapath controls
//   fault                       sticky error flag
//   retired  [CNT_W]            completed-instruction count (wrapping)
module multicycle_controlunit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                memWE,
  output logic                selMemIn,
  output logic                irWE,
  output logic                pcWE,
  output logic                brnch,
  output logic                regWE,
  output logic                accWE,
  output logic                selAluIn,
  output logic                lw,
  output logic                selAccIn,
  output logic [1:0]          cntr_alu,
  output logic                fault,
  output logic [CNT_W-1:0]    retired
);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  logic [2:0] op_low;
  logic       op_illegal;
  logic       mem_phase;
  logic       timer_busy;
  logic       timer_clear;
  logic       timer_expired;

  assign op_low     = opcode_q[2:0];
  // Any set bit above bit 2 makes the opcode illegal.
  assign op_illegal = (opcode_q >> 3) != '0;

  // The wait counter is derived from state rather than from mem_req so the
  // timer never feeds back through the output logic; any cycle that is not
  // an unacknowledged request restarts the count.
  assign mem_phase   = !rst && ((state_q == ST_FETCH) || (state_q == ST_MEM));
  assign timer_busy  = mem_phase && !mem_ack;
  assign timer_clear = !timer_busy;

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .busy   (timer_busy),
    .expired(timer_expired)
  );

  // Next-state and output decode; the reset override at the end guarantees
  // no request or write enable escapes during a reset cycle.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    mem_req  = 1'b0;
    memWE    = 1'b0;
    selMemIn = 1'b0;
    irWE     = 1'b0;
    pcWE     = 1'b0;
    brnch    = 1'b0;
    regWE    = 1'b0;
    accWE    = 1'b0;
    selAluIn = 1'b0;
    lw       = 1'b0;
    selAccIn = 1'b0;
    cntr_alu = ALU_ADD;
    fault    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          irWE     = 1'b1;
          opcode_d = opcode;
          state_d  = ST_DECODE;
        end else if (timer_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        state_d = op_illegal ? ST_FAULT : ST_EXEC;
      end
      ST_EXEC: begin
        pcWE    = 1'b1;
        state_d = ST_FETCH;
        case (op_low)
          OP_ACM: accWE = 1'b1;
          OP_ACMI: begin
            accWE    = 1'b1;
            selAccIn = 1'b1;
          end
          OP_ADD, OP_NAND, OP_LT: begin
            regWE    = 1'b1;
            selAluIn = 1'b1;
            cntr_alu = (op_low == OP_ADD)  ? ALU_ADD :
                       (op_low == OP_NAND) ? ALU_NAND : ALU_LT;
          end
          OP_BNZ: begin
            regWE    = 1'b1;
            brnch    = 1'b1;
            cntr_alu = ALU_NZ;
          end
          default: begin
            // Loads and stores retire only after their data access.
            pcWE    = 1'b0;
            state_d = ST_MEM;
          end
        endcase
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        selMemIn = 1'b1;
        memWE    = (op_low == OP_SW);
        if (mem_ack) begin
          pcWE    = 1'b1;
          state_d = ST_FETCH;
          if (op_low == OP_LW) begin
            regWE = 1'b1;
            lw    = 1'b1;
          end
        end else if (timer_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase

    if (rst) begin
      mem_req  = 1'b0;
      memWE    = 1'b0;
      selMemIn = 1'b0;
      irWE     = 1'b0;
      pcWE     = 1'b0;
      brnch    = 1'b0;
      regWE    = 1'b0;
      accWE    = 1'b0;
      selAluIn = 1'b0;
      lw       = 1'b0;
      selAccIn = 1'b0;
      cntr_alu = ALU_ADD;
      fault    = 1'b0;
    end
  end

  assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, pcWE};
  assign retired   = rst ? '0 : retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      opcode_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controlunit.sv
// Bench for multicycle_controlunit built with OPCODE_W=4 and TIMEOUT=4.
// Instructions are described at transaction level (opcode, fetch wait, MEM
// wait, optional abort) and the bench model expands each one into the
// per-cycle control pattern it must produce; a single compare process
// checks every cycle on the falling edge.
module tb_multicycle_controlunit;

  localparam int TB_TIMEOUT = 4;

  typedef struct packed {
    logic        mem_req;
    logic        memWE;
    logic        selMemIn;
    logic        irWE;
    logic        pcWE;
    logic        brnch;
    logic        regWE;
    logic        accWE;
    logic        selAluIn;
    logic        lw;
    logic        selAccIn;
    logic [1:0]  cntr_alu;
    logic        fault;
    logic [15:0] retired;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  opcode = 4'h0;
  logic        mem_ack = 1'b1;
  logic        mem_req, memWE, selMemIn, irWE, pcWE, brnch;
  logic        regWE, accWE, selAluIn, lw, selAccIn, fault;
  logic [1:0]  cntr_alu;
  logic [15:0] retired;

  outs_t       act;
  outs_t       exp_o = '0;
  bit          exp_valid = 1'b0;
  string       step_name = "none";
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] model_retired = '0;
  int          cyc;

  multicycle_controlunit #(
    .OPCODE_W(4),
    .TIMEOUT (TB_TIMEOUT),
    .CNT_W   (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .mem_ack (mem_ack),
    .mem_req (mem_req),
    .memWE   (memWE),
    .selMemIn(selMemIn),
    .irWE    (irWE),
    .pcWE    (pcWE),
    .brnch   (brnch),
    .regWE   (regWE),
    .accWE   (accWE),
    .selAluIn(selAluIn),
    .lw      (lw),
    .selAccIn(selAccIn),
    .cntr_alu(cntr_alu),
    .fault   (fault),
    .retired (retired)
  );

  always #5 clk = ~clk;

  assign act = {mem_req, memWE, selMemIn, irWE, pcWE, brnch, regWE, accWE,
                selAluIn, lw, selAccIn, cntr_alu, fault, retired};

  // Single compare point, half a cycle after inputs are driven.
  always @(negedge clk) begin
    if (exp_valid) begin
      vectors++;
      if (act !== exp_o) begin
        miscompares++;
        $display("[TB] FAIL %s at %0t: got %h required %h", step_name, $time, act, exp_o);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic a, input logic [3:0] op,
                               input outs_t e, input string name);
    @(posedge clk);
    #1;
    rst       = r;
    mem_ack   = a;
    opcode    = op;
    exp_o     = e;
    step_name = name;
    exp_valid = 1'b1;
  endtask

  task automatic checkOutput(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // Model: an idle cycle has every control low and shows the retired count.
  function automatic outs_t idleOut();
    outs_t r;
    r = '0;
    r.retired = model_retired;
    return r;
  endfunction

  // Model: control pattern of the EXEC cycle by instruction meaning.
  function automatic outs_t execOut(input logic [2:0] op);
    outs_t r;
    r = idleOut();
    case (op)
      3'd0: r.accWE = 1'b1;
      3'd1: begin r.accWE = 1'b1; r.selAccIn = 1'b1; end
      3'd2: begin r.regWE = 1'b1; r.selAluIn = 1'b1; r.cntr_alu = 2'b00; end
      3'd3: begin r.regWE = 1'b1; r.selAluIn = 1'b1; r.cntr_alu = 2'b01; end
      3'd5: begin r.regWE = 1'b1; r.selAluIn = 1'b1; r.cntr_alu = 2'b11; end
      3'd4: begin r.regWE = 1'b1; r.brnch = 1'b1; r.cntr_alu = 2'b10; end
      default: ;
    endcase
    r.pcWE = (op < 3'd6);
    return r;
  endfunction

  task automatic expectFault(input int n, input string name);
    outs_t e;
    for (int i = 0; i < n; i++) begin
      e = idleOut();
      e.fault = 1'b1;
      applyStimulus(1'b0, 1'b1, 4'hF, e, name);
    end
  endtask

  task automatic doReset(input int n);
    model_retired = '0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b1, 4'($urandom_range(0, 15)), '0, "reset");
    end
  endtask

  // Fetch cycle with no ack, pinned to a hand-computed retired value.
  task automatic idleFetch(input int lit, input string name);
    outs_t e;
    checkOutput({"model_", name}, int'(model_retired), lit);
    e = '0;
    e.mem_req = 1'b1;
    e.retired = 16'(lit);
    applyStimulus(1'b0, 1'b0, 4'hF, e, name);
  endtask

  // One instruction: mem_wait<0 means no ack in MEM, abort_at>=0 pulses
  // reset in that MEM cycle instead of continuing.
  task automatic runInstr(input logic [3:0] op, input int fetch_wait, input int mem_wait,
                          input int abort_at, output int cycles);
    outs_t e;
    int    waits;
    logic  ack;
    cycles = 0;
    for (int i = 0; i <= fetch_wait; i++) begin
      e = idleOut();
      e.mem_req = 1'b1;
      e.irWE    = (i == fetch_wait);
      applyStimulus(1'b0, i == fetch_wait, (i == fetch_wait) ? op : 4'hF, e, "fetch");
      cycles++;
    end
    applyStimulus(1'b0, 1'b1, 4'hF, idleOut(), "decode");
    cycles++;
    if (op[3]) begin
      expectFault(3, "illegal_fault");
      cycles += 3;
      return;
    end
    e = execOut(op[2:0]);
    applyStimulus(1'b0, 1'b1, 4'hF, e, "exec");
    cycles++;
    if (e.pcWE) begin
      model_retired++;
      return;
    end
    waits = 0;
    for (int k = 0; k <= TB_TIMEOUT; k++) begin
      if (abort_at >= 0 && waits == abort_at) begin
        model_retired = '0;
        applyStimulus(1'b1, 1'b1, 4'hF, '0, "rst_in_mem");
        cycles++;
        return;
      end
      ack = (mem_wait >= 0) && (waits == mem_wait);
      e = idleOut();
      e.mem_req  = 1'b1;
      e.selMemIn = 1'b1;
      e.memWE    = (op[2:0] == 3'b110);
      if (ack) begin
        e.pcWE = 1'b1;
        if (op[0]) begin
          e.regWE = 1'b1;
          e.lw    = 1'b1;
        end
      end
      applyStimulus(1'b0, ack, 4'hF, e, "mem");
      cycles++;
      if (ack) begin
        model_retired++;
        return;
      end
      waits++;
      if (waits == TB_TIMEOUT) begin
        expectFault(3, "timeout_fault");
        cycles += 3;
        return;
      end
    end
  endtask

  initial begin
    outs_t e;
    $display("[TB] start");
    doReset(3);
    idleFetch(0, "first_free_cycle");

    runInstr(4'h1, 0, 0, -1, cyc);
    checkOutput("acmi_cycles", cyc, 3);
    idleFetch(1, "retired_after_acmi");

    runInstr(4'h0, 0, 0, -1, cyc);
    runInstr(4'h2, 1, 0, -1, cyc);
    checkOutput("add_cycles_fetch_wait1", cyc, 4);
    runInstr(4'h3, 0, 0, -1, cyc);
    runInstr(4'h5, 0, 0, -1, cyc);
    runInstr(4'h4, 0, 0, -1, cyc);
    checkOutput("bnz_cycles", cyc, 3);

    runInstr(4'h7, 0, 2, -1, cyc);
    checkOutput("lw_cycles_ack_delay2", cyc, 6);
    idleFetch(7, "retired_after_lw");

    runInstr(4'h6, 0, 0, -1, cyc);
    checkOutput("sw_cycles", cyc, 4);
    runInstr(4'h6, 0, 3, -1, cyc);
    checkOutput("sw_ack_at_limit_cycles", cyc, 7);
    idleFetch(9, "retired_after_sw_limit");

    runInstr(4'h6, 0, -1, -1, cyc);
    checkOutput("sw_timeout_cycles", cyc, 10);

    doReset(2);
    runInstr(4'h0, 0, 0, -1, cyc);
    runInstr(4'hA, 0, 0, -1, cyc);
    checkOutput("illegal_cycles", cyc, 5);
    e = '0;
    e.fault   = 1'b1;
    e.retired = 16'd1;
    applyStimulus(1'b0, 1'b1, 4'h0, e, "illegal_retired_unchanged");

    doReset(1);
    idleFetch(0, "after_reset_from_fault");
    runInstr(4'h0, 0, 0, -1, cyc);
    runInstr(4'h7, 0, -1, 1, cyc);
    checkOutput("lw_abort_cycles", cyc, 5);
    idleFetch(0, "after_abort");
    runInstr(4'h0, 0, 0, -1, cyc);
    idleFetch(1, "retired_after_restart");

    @(negedge clk);
    #1;
    exp_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
